dlx_set_cond_unit: RTL and testbench

- Parametrised, pipelined set-condition unit for the extended DLX datapath.
- Compares two operands under a selectable condition (SEQ/SNE/SLT/SGT/SLE/SGE/false/true), signed or unsigned.
- Produces the 1-bit outcome and its zero-extended WIDTH-bit form, ready for register write-back.
- Adds valid/ready flow control, configurable pipeline depth and a saturating count of true results for profiling.

---
 rtl/dlx_cmp_pkg.sv | 35 +++
 rtl/dlx_set_cond_unit_if.sv | 34 +++
 rtl/dlx_cmp_pipe_stage.sv | 47 ++++
 rtl/dlx_set_cond_unit.sv | 89 ++++++++
 tb/tb_dlx_set_cond_unit.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_cmp_pkg.sv
// Shared definitions for the DLX set-condition unit: condition codes and the
// outcome decode from equality / less-than flags.
package dlx_cmp_pkg;

  localparam int COND_W = 3;

  typedef enum logic [COND_W-1:0] {
    COND_SEQ    = 3'd0,
    COND_SNE    = 3'd1,
    COND_SLT    = 3'd2,
    COND_SGT    = 3'd3,
    COND_SLE    = 3'd4,
    COND_SGE    = 3'd5,
    COND_SFALSE = 3'd6,
    COND_STRUE  = 3'd7
  } cond_e;

  // The ordering conditions are all derived from the same two flags.
  function automatic logic cond_eval(input cond_e cond, input logic eq, input logic lt);
    logic r;
    case (cond)
      COND_SEQ:    r = eq;
      COND_SNE:    r = !eq;
      COND_SLT:    r = lt;
      COND_SGT:    r = !lt && !eq;
      COND_SLE:    r = lt || eq;
      COND_SGE:    r = !lt;
      COND_SFALSE: r = 1'b0;
      COND_STRUE:  r = 1'b1;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dlx_set_cond_unit_if.sv
// Operand/result bus of the set-condition unit; master drives operands and
// consumes results, slave is the unit itself.
interface dlx_set_cond_unit_if
  import dlx_cmp_pkg::*;
#(
  parameter int OP_WIDTH  = 32,
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);

  logic                 IN_VALID;
  logic                 IN_READY;
  logic [OP_WIDTH-1:0]  OPA;
  logic [OP_WIDTH-1:0]  OPB;
  logic [COND_W-1:0]    COND;
  logic                 SIGNED_MODE;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic                 COMP_OUT;
  logic [WIDTH-1:0]     COMP_OUT_WIDE;
  logic [CNT_WIDTH-1:0] TRUE_CNT;
  logic                 CNT_CLR;

  modport master (
    output IN_VALID, OPA, OPB, COND, SIGNED_MODE, OUT_READY, CNT_CLR,
    input  IN_READY, OUT_VALID, COMP_OUT, COMP_OUT_WIDE, TRUE_CNT
  );

  modport slave (
    input  IN_VALID, OPA, OPB, COND, SIGNED_MODE, OUT_READY, CNT_CLR,
    output IN_READY, OUT_VALID, COMP_OUT, COMP_OUT_WIDE, TRUE_CNT
  );

endinterface

// File: rtl/dlx_cmp_pipe_stage.sv
// One elastic {valid, data} register stage. Loads when empty or when its
// current content leaves in the same cycle; ready never depends on in_valid_i.
module dlx_cmp_pipe_stage #(
  parameter int DATA_W = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/dlx_set_cond_unit.sv
// Pipelined DLX set-condition unit: compare decode, STAGES elastic stages,
// zero-extended result and a saturating count of delivered true results.
module dlx_set_cond_unit
  import dlx_cmp_pkg::*;
#(
  parameter int OP_WIDTH  = 32,
  parameter int WIDTH     = 32,
  parameter int STAGES    = 1,
  parameter int CNT_WIDTH = 16
) (
  input logic               CLK,
  input logic               RESET_N,
  dlx_set_cond_unit_if.slave bus
);

  if (STAGES < 1 || STAGES > 2) begin : g_bad_stages
    $error("dlx_set_cond_unit: STAGES must be 1 or 2");
  end
  if (OP_WIDTH < 2) begin : g_bad_op_width
    $error("dlx_set_cond_unit: OP_WIDTH must be at least 2");
  end
  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_width
    $error("dlx_set_cond_unit: WIDTH and CNT_WIDTH must be at least 1");
  end

  logic eq, lt, outcome;

  always_comb begin
    eq = (bus.OPA == bus.OPB);
    if (bus.SIGNED_MODE) lt = ($signed(bus.OPA) < $signed(bus.OPB));
    else                 lt = (bus.OPA < bus.OPB);
    outcome = cond_eval(cond_e'(bus.COND), eq, lt);
  end

  // Index k is the boundary feeding stage k; index STAGES is the output port.
  logic [STAGES:0] pv, pr, pd;

  assign pv[0]        = bus.IN_VALID;
  assign pd[0]        = outcome;
  assign pr[STAGES]   = bus.OUT_READY;
  assign bus.IN_READY = pr[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    dlx_cmp_pipe_stage #(.DATA_W(1)) u_stage (
      .clk_i       (CLK),
      .rst_ni      (RESET_N),
      .in_valid_i  (pv[k]),
      .in_ready_o  (pr[k]),
      .in_data_i   (pd[k]),
      .out_valid_o (pv[k+1]),
      .out_ready_i (pr[k+1]),
      .out_data_o  (pd[k+1])
    );
  end

  logic out_valid, comp_out, out_hs;

  assign out_valid     = pv[STAGES];
  assign comp_out      = pd[STAGES];
  assign out_hs        = out_valid && bus.OUT_READY;
  assign bus.OUT_VALID = out_valid;
  assign bus.COMP_OUT  = comp_out;

  if (WIDTH == 1) begin : g_wide_1
    assign bus.COMP_OUT_WIDE = comp_out;
  end else begin : g_wide_n
    assign bus.COMP_OUT_WIDE = {{(WIDTH-1){1'b0}}, comp_out};
  end

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.CNT_CLR) begin
      cnt_d = '0;
    end else if (out_hs && comp_out && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.TRUE_CNT = cnt_q;

endmodule

// File: tb/tb_dlx_set_cond_unit.sv
// Bench for dlx_set_cond_unit: three configurations against a queue-based
// reference model, plus literal directed expectations.
`timescale 1ns/1ps
module tb_dlx_set_cond_unit;
  import dlx_cmp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n1, rst_n2, rst_n3;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dlx_set_cond_unit_if #(.OP_WIDTH(32), .WIDTH(32), .CNT_WIDTH(16)) if1 ();
  dlx_set_cond_unit_if #(.OP_WIDTH(32), .WIDTH(32), .CNT_WIDTH(16)) if2 ();
  dlx_set_cond_unit_if #(.OP_WIDTH(16), .WIDTH(8),  .CNT_WIDTH(4))  if3 ();

  dlx_set_cond_unit #(.OP_WIDTH(32), .WIDTH(32), .STAGES(1), .CNT_WIDTH(16))
    u1 (.CLK(clk), .RESET_N(rst_n1), .bus(if1));
  dlx_set_cond_unit #(.OP_WIDTH(32), .WIDTH(32), .STAGES(2), .CNT_WIDTH(16))
    u2 (.CLK(clk), .RESET_N(rst_n2), .bus(if2));
  dlx_set_cond_unit #(.OP_WIDTH(16), .WIDTH(8),  .STAGES(2), .CNT_WIDTH(4))
    u3 (.CLK(clk), .RESET_N(rst_n3), .bus(if3));

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference compare: operands become plain integers, signed when asked.
  function automatic bit ref_cond(input logic [63:0] a, input logic [63:0] b,
                                  input int c, input bit sgn, input int w);
    longint x, y;
    bit r;
    x = longint'(a);
    y = longint'(b);
    if (sgn) begin
      if (a[w-1]) x = x - (longint'(1) << w);
      if (b[w-1]) y = y - (longint'(1) << w);
    end
    case (c)
      0: r = (x == y);
      1: r = (x != y);
      2: r = (x <  y);
      3: r = (x >  y);
      4: r = (x <= y);
      5: r = (x >= y);
      6: r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_op(input int w);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom % 6)
      0: r = 32'd0;
      1: r = 32'd1;
      2: r = mask;
      3: r = 32'd1 << (w - 1);
      4: r = (32'd1 << (w - 1)) - 32'd1;
      default: r = $urandom & mask;
    endcase
    return r;
  endfunction

  // Model: each DUT is a FIFO of accepted items; an item reaches the output
  // STAGES cycles after acceptance, and the buffer holds at most STAGES items.
  int     m_rdy [3][8];
  bit     m_val [3][8];
  int     m_hd  [3];
  int     m_n   [3];
  longint m_cnt [3];
  bit     m_act [3];
  bit     m_fresh [3];

  task automatic model_reset(input int d);
    m_hd[d] = 0; m_n[d] = 0; m_cnt[d] = 0; m_act[d] = 1'b1; m_fresh[d] = 1'b1;
  endtask

  task automatic model_step(input int d, input int w_op, input int cw, input int st,
                            input logic rst_n, input logic in_valid, input logic in_ready,
                            input logic [63:0] opa, input logic [63:0] opb,
                            input logic [2:0] cond, input logic sgn,
                            input logic out_valid, input logic out_ready, input logic comp_out,
                            input logic [63:0] wide, input logic [63:0] tcnt, input logic clr);
    bit ev, hv, er;
    string p;
    int tl;
    longint cmax;
    if (!m_act[d]) begin
      if (!rst_n) model_reset(d);
      return;
    end
    p    = $sformatf("u%0d", d + 1);
    cmax = (longint'(1) << cw) - 1;
    ev = (m_n[d] > 0) && (cyc >= m_rdy[d][m_hd[d]]);
    hv = ev ? m_val[d][m_hd[d]] : 1'b0;
    er = (m_n[d] < st) || out_ready;
    chk({p, ".out_valid"}, out_valid, ev);
    if (ev || m_fresh[d]) begin
      chk({p, ".comp_out"}, comp_out, hv);
      chk({p, ".comp_out_wide"}, wide, hv);
    end
    if (ev) m_fresh[d] = 1'b0;
    chk({p, ".in_ready"}, in_ready, er);
    chk({p, ".true_cnt"}, tcnt, m_cnt[d]);
    if (!rst_n) begin
      model_reset(d);
    end else begin
      if (clr) m_cnt[d] = 0;
      else if (ev && out_ready && hv && m_cnt[d] < cmax) m_cnt[d]++;
      if (ev && out_ready) begin
        m_hd[d] = (m_hd[d] + 1) % 8;
        m_n[d]--;
      end
      if (in_valid && er) begin
        tl = (m_hd[d] + m_n[d]) % 8;
        m_rdy[d][tl] = cyc + st;
        m_val[d][tl] = ref_cond(opa, opb, int'(cond), sgn, w_op);
        m_n[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 32, 16, 1, rst_n1, if1.IN_VALID, if1.IN_READY, if1.OPA, if1.OPB, if1.COND,
               if1.SIGNED_MODE, if1.OUT_VALID, if1.OUT_READY, if1.COMP_OUT, if1.COMP_OUT_WIDE,
               if1.TRUE_CNT, if1.CNT_CLR);
    model_step(1, 32, 16, 2, rst_n2, if2.IN_VALID, if2.IN_READY, if2.OPA, if2.OPB, if2.COND,
               if2.SIGNED_MODE, if2.OUT_VALID, if2.OUT_READY, if2.COMP_OUT, if2.COMP_OUT_WIDE,
               if2.TRUE_CNT, if2.CNT_CLR);
    model_step(2, 16, 4, 2, rst_n3, if3.IN_VALID, if3.IN_READY, if3.OPA, if3.OPB, if3.COND,
               if3.SIGNED_MODE, if3.OUT_VALID, if3.OUT_READY, if3.COMP_OUT, if3.COMP_OUT_WIDE,
               if3.TRUE_CNT, if3.CNT_CLR);
  end

  // Directed single-stage table: operands, condition, signedness, expected wide result.
  localparam logic [31:0] T_A [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                                       32'd5, 32'd5, 32'h0000_DEAD, 32'd1, 32'h8000_0000, 32'h8000_0000};
  localparam logic [31:0] T_B [10] = '{32'd1, 32'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                       32'd5, 32'd5, 32'h0000_DEAD, 32'd2, 32'd0, 32'd0};
  localparam logic [2:0]  T_C [10] = '{3'd2, 3'd2, 3'd5, 3'd5, 3'd0, 3'd1, 3'd6, 3'd7, 3'd4, 3'd3};
  localparam logic        T_S [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [31:0] T_E [10] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
  localparam logic        BP_E [3] = '{1'b1, 1'b0, 1'b1};

  bit bp_got[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n1 = 1'b0; rst_n2 = 1'b0; rst_n3 = 1'b0;
    if1.IN_VALID = 0; if1.OPA = '0; if1.OPB = '0; if1.COND = '0; if1.SIGNED_MODE = 0;
    if1.OUT_READY = 0; if1.CNT_CLR = 0;
    if2.IN_VALID = 0; if2.OPA = '0; if2.OPB = '0; if2.COND = '0; if2.SIGNED_MODE = 0;
    if2.OUT_READY = 0; if2.CNT_CLR = 0;
    if3.IN_VALID = 0; if3.OPA = '0; if3.OPB = '0; if3.COND = '0; if3.SIGNED_MODE = 0;
    if3.OUT_READY = 0; if3.CNT_CLR = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n1 = 1'b1; rst_n2 = 1'b1; rst_n3 = 1'b1;
    #1;
    chk("reset.u1.out_valid", if1.OUT_VALID, 0);
    chk("reset.u1.wide", if1.COMP_OUT_WIDE, 0);
    chk("reset.u1.true_cnt", if1.TRUE_CNT, 0);
    chk("reset.u1.in_ready", if1.IN_READY, 1);
    chk("reset.u3.wide", if3.COMP_OUT_WIDE, 0);

    fork
      begin : p_u1
        logic [31:0] ra;
        if1.OUT_READY = 1;
        for (int i = 0; i < 10; i++) begin
          if1.IN_VALID = 1; if1.OPA = T_A[i]; if1.OPB = T_B[i];
          if1.COND = T_C[i]; if1.SIGNED_MODE = T_S[i];
          tick();
          chk($sformatf("u1.dir%0d.out_valid", i), if1.OUT_VALID, 1);
          chk($sformatf("u1.dir%0d.wide", i), if1.COMP_OUT_WIDE, T_E[i]);
        end
        if1.IN_VALID = 0;
        tick();
        chk("u1.drain.out_valid", if1.OUT_VALID, 0);
        repeat (1500) begin
          ra = rnd_op(32);
          if1.IN_VALID    = ($urandom % 4 != 0);
          if1.OUT_READY   = ($urandom % 3 != 0);
          if1.OPA         = ra;
          if1.OPB         = ($urandom % 4 == 0) ? ra : rnd_op(32);
          if1.COND        = 3'($urandom % 8);
          if1.SIGNED_MODE = 1'($urandom % 2);
          if1.CNT_CLR     = ($urandom % 64 == 0);
          tick();
        end
        if1.IN_VALID = 0; if1.OUT_READY = 1; if1.CNT_CLR = 1;
        repeat (3) tick();
        if1.CNT_CLR = 0; if1.COND = COND_STRUE; if1.IN_VALID = 1;
        repeat (65534) tick();
        if1.IN_VALID = 0;
        repeat (2) tick();
        chk("u1.sat.preload", if1.TRUE_CNT, 16'hFFFE);
        if1.IN_VALID = 1;
        repeat (3) tick();
        if1.IN_VALID = 0;
        repeat (2) tick();
        chk("u1.sat.reached", if1.TRUE_CNT, 16'hFFFF);
        if1.IN_VALID = 1;
        repeat (2) tick();
        if1.IN_VALID = 0;
        repeat (2) tick();
        chk("u1.sat.held", if1.TRUE_CNT, 16'hFFFF);
        if1.IN_VALID = 1;
        tick();
        if1.IN_VALID = 0; if1.CNT_CLR = 1;
        #1;
        chk("u1.clr.true_pending", if1.OUT_VALID && if1.COMP_OUT, 1);
        tick();
        if1.CNT_CLR = 0;
        chk("u1.clr.priority", if1.TRUE_CNT, 0);
        tick();
      end

      begin : p_u2
        logic [31:0] ra;
        if2.OUT_READY = 0; if2.SIGNED_MODE = 0; if2.COND = COND_SEQ;
        if2.IN_VALID = 1; if2.OPA = 32'd1; if2.OPB = 32'd1;
        #1 chk("u2.bp.ready0", if2.IN_READY, 1);
        tick();
        if2.OPA = 32'd1; if2.OPB = 32'd2;
        #1 chk("u2.bp.ready1", if2.IN_READY, 1);
        tick();
        if2.OPA = 32'd3; if2.OPB = 32'd3;
        #1 chk("u2.bp.ready_full", if2.IN_READY, 0);
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("u2.bp.hold%0d.valid", k), if2.OUT_VALID, 1);
          chk($sformatf("u2.bp.hold%0d.value", k), if2.COMP_OUT, 1);
          tick();
          chk($sformatf("u2.bp.hold%0d.ready", k), if2.IN_READY, 0);
        end
        if2.OUT_READY = 1;
        #1 chk("u2.bp.ready_release", if2.IN_READY, 1);
        for (int k = 0; k < 8; k++) begin
          if (if2.OUT_VALID) bp_got.push_back(if2.COMP_OUT);
          tick();
          if (k == 0) if2.IN_VALID = 0;
        end
        chk("u2.bp.count", bp_got.size(), 3);
        for (int k = 0; k < 3; k++)
          if (k < bp_got.size()) chk($sformatf("u2.bp.order%0d", k), bp_got[k], BP_E[k]);
        chk("u2.bp.true_cnt", if2.TRUE_CNT, 2);
        if2.OUT_READY = 0; if2.COND = COND_STRUE; if2.IN_VALID = 1;
        repeat (2) tick();
        if2.IN_VALID = 0;
        #1 chk("u2.rst.inflight", if2.OUT_VALID, 1);
        rst_n2 = 0;
        tick();
        rst_n2 = 1;
        #1;
        chk("u2.rst.out_valid", if2.OUT_VALID, 0);
        chk("u2.rst.true_cnt", if2.TRUE_CNT, 0);
        chk("u2.rst.in_ready", if2.IN_READY, 1);
        if2.OUT_READY = 1;
        for (int k = 0; k < 5; k++) begin
          tick();
          chk($sformatf("u2.rst.no_stale%0d", k), if2.OUT_VALID, 0);
        end
        repeat (3000) begin
          ra = rnd_op(32);
          rst_n2          = ($urandom % 200 != 0);
          if2.IN_VALID    = ($urandom % 3 != 0);
          if2.OUT_READY   = ($urandom % 2 != 0);
          if2.OPA         = ra;
          if2.OPB         = ($urandom % 4 == 0) ? ra : rnd_op(32);
          if2.COND        = 3'($urandom % 8);
          if2.SIGNED_MODE = 1'($urandom % 2);
          if2.CNT_CLR     = ($urandom % 100 == 0);
          tick();
        end
        rst_n2 = 1; if2.IN_VALID = 0; if2.CNT_CLR = 0;
        tick();
      end

      begin : p_u3
        logic [31:0] ra, rb;
        if3.OUT_READY = 1; if3.SIGNED_MODE = 1; if3.COND = COND_SGT;
        if3.IN_VALID = 1; if3.OPA = 16'd3; if3.OPB = 16'd2;
        tick();
        if3.OPA = 16'd2; if3.OPB = 16'd3;
        tick();
        chk("u3.sgt.valid", if3.OUT_VALID, 1);
        chk("u3.sgt.wide", if3.COMP_OUT_WIDE, 8'h01);
        if3.IN_VALID = 0;
        tick();
        chk("u3.sgt_swap.valid", if3.OUT_VALID, 1);
        chk("u3.sgt_swap.wide", if3.COMP_OUT_WIDE, 8'h00);
        repeat (3000) begin
          ra = rnd_op(16);
          rb = ($urandom % 4 == 0) ? ra : rnd_op(16);
          if3.IN_VALID    = ($urandom % 4 != 0);
          if3.OUT_READY   = ($urandom % 4 != 0);
          if3.OPA         = ra[15:0];
          if3.OPB         = rb[15:0];
          if3.COND        = ($urandom % 2 != 0) ? 3'(COND_STRUE) : 3'($urandom % 8);
          if3.SIGNED_MODE = 1'($urandom % 2);
          if3.CNT_CLR     = ($urandom % 150 == 0);
          tick();
        end
        if3.IN_VALID = 0; if3.CNT_CLR = 0;
        tick();
      end
    join

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
